// File: rtl/alu_iter_pkg.sv
// Shared encodings for the iterative execute-stage ALU: unit/sub-op codes, FSM states
// and the divide-by-zero quotient. The M extension is compiled in with ALU_ITER_M_EXT_EN.
package alu_iter_pkg;

    localparam logic [3:0] FUNC_ADD   = 4'd0;
    localparam logic [3:0] FUNC_SHIFT = 4'd1;
    localparam logic [3:0] FUNC_CMP   = 4'd2;
    localparam logic [3:0] FUNC_DIV   = 4'd3;
    localparam logic [3:0] FUNC_LOGIC = 4'd4;
    localparam logic [3:0] FUNC_MUL   = 4'd5;
    localparam logic [3:0] FUNC_AUIPC = 4'd6;
    localparam logic [3:0] FUNC_LUI   = 4'd7;

    localparam logic [3:0] ADD_ADD    = 4'd0;
    localparam logic [3:0] ADD_SUB    = 4'd1;

    localparam logic [3:0] SHIFT_SLL  = 4'd0;
    localparam logic [3:0] SHIFT_SRL  = 4'd1;
    localparam logic [3:0] SHIFT_SRA  = 4'd2;

    localparam logic [3:0] CMP_SLT    = 4'd0;
    localparam logic [3:0] CMP_SLTU   = 4'd1;

    localparam logic [3:0] LOGIC_AND  = 4'd0;
    localparam logic [3:0] LOGIC_OR   = 4'd1;
    localparam logic [3:0] LOGIC_XOR  = 4'd2;

    localparam logic [3:0] MUL_MUL    = 4'd0;
    localparam logic [3:0] MUL_MULH   = 4'd1;
    localparam logic [3:0] MUL_MULHSU = 4'd2;
    localparam logic [3:0] MUL_MULHU  = 4'd3;

    localparam logic [3:0] DIV_DIV    = 4'd0;
    localparam logic [3:0] DIV_DIVU   = 4'd1;
    localparam logic [3:0] DIV_REM    = 4'd2;
    localparam logic [3:0] DIV_REMU   = 4'd3;

    // Sliced down to XLEN at the point of use.
    localparam logic [127:0] DIV_ZERO_Q = {128{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/alu_iter_simple.sv
// Single-cycle combinational datapath: adder, shifter, compare, logic, auipc and lui.
// Unknown unit codes (and M-extension codes when they reach here) produce 0.
module alu_iter_simple
    import alu_iter_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      func_control,
    input  logic [3:0]      inner_control,
    output logic [XLEN-1:0] result
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;

    assign shamt = src2[SH_W-1:0];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no
        // path through the case statements can leave it unassigned and infer a latch.
        result = '0;
        unique case (func_control)
            FUNC_ADD, FUNC_AUIPC: begin
                // Any adder sub-op other than sub adds; auipc is a plain add here.
                if (func_control == FUNC_ADD && inner_control == ADD_SUB) begin
                    result = src1 - src2;
                end else begin
                    result = src1 + src2;
                end
            end
            FUNC_SHIFT: begin
                case (inner_control)
                    SHIFT_SLL: result = src1 << shamt;
                    SHIFT_SRL: result = src1 >> shamt;
                    SHIFT_SRA: result = $unsigned($signed(src1) >>> shamt);
                    default:   result = '0;
                endcase
            end
            FUNC_CMP: begin
                case (inner_control)
                    CMP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
                    CMP_SLTU: result = {{(XLEN-1){1'b0}}, (src1 < src2)};
                    default:  result = '0;
                endcase
            end
            FUNC_LOGIC: begin
                case (inner_control)
                    LOGIC_AND: result = src1 & src2;
                    LOGIC_OR:  result = src1 | src2;
                    LOGIC_XOR: result = src1 ^ src2;
                    default:   result = '0;
                endcase
            end
            FUNC_LUI: result = src2;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_iter_top.sv
// Multi-cycle ALU: registered single-cycle ops plus radix-2 shift-add MUL and restoring
// DIV engines (compiled in when ALU_ITER_M_EXT_EN is defined), with valid/ready and kill.
module alu_iter_top
    import alu_iter_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [3:0]      func_control,
    input  logic [3:0]      inner_control,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_out,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] simple_result;
    logic            accept;

    assign in_ready   = (state_q == S_IDLE) && !rst;
    assign accept     = in_valid && in_ready && !kill;
    assign out_valid  = (state_q == S_DONE);
    assign result_out = result_q;

    alu_iter_simple #(.XLEN(XLEN)) u_simple (
        .src1          (src1),
        .src2          (src2),
        .func_control  (func_control),
        .inner_control (inner_control),
        .result        (simple_result)
    );

`ifdef ALU_ITER_M_EXT_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // work_q holds {upper product, multiplier} for MUL and {remainder, quotient} for DIV.
    logic [2*XLEN-1:0] work_q, work_d;
    logic [XLEN-1:0]   mag_q, mag_d;
    logic [XLEN-1:0]   src1_q, src1_d;
    logic [XLEN-1:0]   src2_q, src2_d;
    logic [3:0]        inner_q, inner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_neg1, in_neg2;
    logic [XLEN-1:0]   in_mag1, in_mag2;
    logic              iter_last;
    logic              mul_neg;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_step;
    logic              fix_signed;
    logic [XLEN-1:0]   fix_quot;
    logic [XLEN-1:0]   fix_rem;
    logic [XLEN-1:0]   fix_result;

    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

    // Operand signs seen by the engines at acceptance.
    always_comb begin
        in_neg1 = 1'b0;
        in_neg2 = 1'b0;
        if (func_control == FUNC_MUL) begin
            in_neg1 = src1[XLEN-1] && (inner_control == MUL_MULH || inner_control == MUL_MULHSU);
            in_neg2 = src2[XLEN-1] && (inner_control == MUL_MULH);
        end else if (func_control == FUNC_DIV) begin
            in_neg1 = src1[XLEN-1] && (inner_control == DIV_DIV || inner_control == DIV_REM);
            in_neg2 = src2[XLEN-1] && (inner_control == DIV_DIV || inner_control == DIV_REM);
        end
        in_mag1 = in_neg1 ? -src1 : src1;
        in_mag2 = in_neg2 ? -src2 : src2;
    end

    assign iter_last = (cnt_q == CNT_W'(XLEN - 1));
    assign mul_neg   = (inner_q == MUL_MULH   && (src1_q[XLEN-1] ^ src2_q[XLEN-1]))
                    || (inner_q == MUL_MULHSU && src1_q[XLEN-1]);

    assign mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, mag_q} : '0);
    assign mul_step  = {mul_sum, work_q[XLEN-1:1]};

    assign div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, mag_q});
    assign div_diff  = div_shift - {1'b0, mag_q};
    assign div_step  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        work_q[XLEN-2:0], div_ge};

    // Sign fix-up and the two architectural corner cases after the magnitude divide.
    always_comb begin
        fix_signed = (inner_q == DIV_DIV) || (inner_q == DIV_REM);
        fix_quot   = (fix_signed && (src1_q[XLEN-1] ^ src2_q[XLEN-1]))
                   ? -work_q[XLEN-1:0] : work_q[XLEN-1:0];
        fix_rem    = (fix_signed && src1_q[XLEN-1])
                   ? -work_q[2*XLEN-1:XLEN] : work_q[2*XLEN-1:XLEN];
        if (src2_q == '0) begin
            fix_quot = DIV_ZERO_Q[XLEN-1:0];
            fix_rem  = src1_q;
        end else if (fix_signed && src1_q == MOST_NEG && src2_q == '1) begin
            fix_quot = src1_q;
            fix_rem  = '0;
        end
        fix_result = (inner_q == DIV_REM || inner_q == DIV_REMU) ? fix_rem : fix_quot;
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
`ifdef ALU_ITER_M_EXT_EN
        work_d   = work_q;
        mag_d    = mag_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        inner_d  = inner_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    result_d = simple_result;
                    state_d  = S_DONE;
`ifdef ALU_ITER_M_EXT_EN
                    src1_d  = src1;
                    src2_d  = src2;
                    inner_d = inner_control;
                    cnt_d   = '0;
                    if (func_control == FUNC_MUL) begin
                        state_d = S_MUL;
                        mag_d   = in_mag1;
                        work_d  = {{XLEN{1'b0}}, in_mag2};
                    end else if (func_control == FUNC_DIV) begin
                        state_d = S_DIV;
                        mag_d   = in_mag2;
                        work_d  = {{XLEN{1'b0}}, in_mag1};
                    end
`endif
                end
            end
`ifdef ALU_ITER_M_EXT_EN
            S_MUL: begin
                work_d = (iter_last && mul_neg) ? -mul_step : mul_step;
                cnt_d  = cnt_q + 1'b1;
                if (iter_last) begin
                    state_d  = S_DONE;
                    result_d = (inner_q == MUL_MUL) ? work_d[XLEN-1:0]
                                                    : work_d[2*XLEN-1:XLEN];
                end
            end
            S_DIV: begin
                work_d = div_step;
                cnt_d  = cnt_q + 1'b1;
                if (iter_last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_result;
                state_d  = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values,
    // independent of the order in which the simulator evaluates the processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are cleared as well, not only control, so
            // result_out reads 0 straight out of reset and no stale operand survives.
            state_q  <= S_IDLE;
            result_q <= '0;
`ifdef ALU_ITER_M_EXT_EN
            work_q   <= '0;
            mag_q    <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            inner_q  <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
`ifdef ALU_ITER_M_EXT_EN
            work_q   <= work_d;
            mag_q    <= mag_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            inner_q  <= inner_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_iter_top.sv
// Self-checking bench for alu_iter_top (XLEN=64): vector table with a result scoreboard,
// plus hand-written reset, backpressure and kill sequences. Honours ALU_ITER_M_EXT_EN.
module tb_alu_iter_top;

    localparam int XLEN = 64;

    typedef struct {
        string       name;
        logic [3:0]  func;
        logic [3:0]  inner;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [3:0]      func_control;
    logic [3:0]      inner_control;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_out;
    logic            busy;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    vec_t        vecs[$];

    always #5 clk = ~clk;

    alu_iter_top #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .src1          (src1),
        .src2          (src2),
        .func_control  (func_control),
        .inner_control (inner_control),
        .kill          (kill),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_out    (result_out),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] f, input logic [3:0] inn,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int lat);
        vec_t v;
        v.name = name; v.func = f; v.inner = inn;
        v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Drive one op, measure accept-to-out_valid latency, compare against the scoreboard.
    task automatic do_op(input string name, input logic [3:0] f, input logic [3:0] inn,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int lat_exp);
        int          lat;
        logic [63:0] want;
        @(negedge clk);
        func_control  = f;
        inner_control = inn;
        src1          = a;
        src2          = b;
        in_valid      = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(lat_exp));
        want = sb.pop_front();
        check({name, " result"}, result_out, want);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        bit          seen;

        rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; func_control = '0; inner_control = '0;

        add_vec("add",      4'd0, 4'd0, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 1);
        add_vec("sub",      4'd0, 4'd1, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
        add_vec("sll",      4'd1, 4'd0, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1);
        add_vec("sll_wrap", 4'd1, 4'd0, 64'd1, 64'h41, 64'd2, 1);
        add_vec("srl",      4'd1, 4'd1, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000, 1);
        add_vec("sra",      4'd1, 4'd2, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1);
        add_vec("slt",      4'd2, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
        add_vec("sltu",     4'd2, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
        add_vec("and",      4'd4, 4'd0, 64'hF0F0_A5A5_0000_FFFF, 64'h0FF0_5AA5_FFFF_00FF, 64'h00F0_00A5_0000_00FF, 1);
        add_vec("or",       4'd4, 4'd1, 64'hF0F0_A5A5_0000_FFFF, 64'h0FF0_5AA5_FFFF_00FF, 64'hFFF0_FFA5_FFFF_FFFF, 1);
        add_vec("xor",      4'd4, 4'd2, 64'hF0F0_A5A5_0000_FFFF, 64'h0FF0_5AA5_FFFF_00FF, 64'hFF00_FF00_FFFF_FF00, 1);
        add_vec("auipc",    4'd6, 4'd0, 64'h1000, 64'h234, 64'h1234, 1);
        add_vec("lui",      4'd7, 4'd0, 64'h1111, 64'hABCD_E000, 64'hABCD_E000, 1);
        add_vec("unknown",  4'd9, 4'd0, 64'd3, 64'd4, 64'd0, 1);
`ifdef ALU_ITER_M_EXT_EN
        add_vec("mul_m1",    4'd5, 4'd0, '1, '1, 64'd1, 65);
        add_vec("mulh_m1",   4'd5, 4'd1, '1, '1, 64'd0, 65);
        add_vec("mulhu_m1",  4'd5, 4'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        add_vec("mulhsu_m1", 4'd5, 4'd2, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        add_vec("mul_3x4",   4'd5, 4'd0, 64'd3, 64'd4, 64'd12, 65);
        add_vec("div_by0",   4'd3, 4'd0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        add_vec("rem_by0",   4'd3, 4'd2, 64'd7, 64'd0, 64'd7, 66);
        add_vec("div_ovf",   4'd3, 4'd0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 66);
        add_vec("rem_ovf",   4'd3, 4'd2, 64'h8000_0000_0000_0000, '1, 64'd0, 66);
        add_vec("rem_neg",   4'd3, 4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        add_vec("div_neg",   4'd3, 4'd0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        add_vec("divu",      4'd3, 4'd1, 64'd100, 64'd7, 64'd14, 66);
        add_vec("remu",      4'd3, 4'd3, 64'd100, 64'd7, 64'd2, 66);
`else
        add_vec("mul_off",   4'd5, 4'd0, 64'd3, 64'd4, 64'd0, 1);
        add_vec("div_off",   4'd3, 4'd1, 64'd100, 64'd7, 64'd0, 1);
`endif

        // Reset behaviour.
        repeat (3) @(negedge clk);
        check("in_ready_in_reset", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);
        check("out_valid_after_reset", 64'(out_valid), 64'd0);
        check("result_after_reset", result_out, 64'd0);
        check("busy_after_reset", 64'(busy), 64'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].name, vecs[i].func, vecs[i].inner, vecs[i].a, vecs[i].b,
                  vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: result held, in_ready low, pending op waits for the handshake.
        @(negedge clk);
        func_control = 4'd0; inner_control = 4'd0; src1 = 64'd10; src2 = 64'd20;
        in_valid = 1'b1;
        sb.push_back(64'd30);
        @(posedge clk);
        @(negedge clk);
        inner_control = 4'd1; src1 = 64'd50; src2 = 64'd8;
        sb.push_back(64'd42);
        held = result_out;
        check("bp_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_result_stable", result_out, held);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        check("bp_first_result", result_out, sb.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_not_yet_valid", 64'(out_valid), 64'd0);
        check("bp_ready_after_handshake", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", 64'(out_valid), 64'd1);
        check("bp_second_result", result_out, sb.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Kill presented with an op: the op is not accepted.
        @(negedge clk);
        func_control = 4'd0; inner_control = 4'd0; src1 = 64'd1; src2 = 64'd1;
        in_valid = 1'b1; kill = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; kill = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            seen |= out_valid;
            @(negedge clk);
        end
        check("kill_same_cycle_no_valid", 64'(seen), 64'd0);

        // Kill while DONE: out_valid drops the next cycle.
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("kill_done_valid_before", 64'(out_valid), 64'd1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_done_valid_after", 64'(out_valid), 64'd0);
        check("kill_done_in_ready", 64'(in_ready), 64'd1);

`ifdef ALU_ITER_M_EXT_EN
        // Kill in the 20th DIV cycle.
        @(negedge clk);
        func_control = 4'd3; inner_control = 4'd0; src1 = 64'd1000; src2 = 64'd3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("div_busy", 64'(busy), 64'd1);
        repeat (19) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_div_in_ready", 64'(in_ready), 64'd1);
        check("kill_div_busy", 64'(busy), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            seen |= out_valid;
            @(negedge clk);
        end
        check("kill_div_no_valid", 64'(seen), 64'd0);
        do_op("divu_after_kill", 4'd3, 4'd1, 64'd100, 64'd7, 64'd14, 66);
`endif

        // Reset in the middle of an op discards it.
        @(negedge clk);
        func_control = 4'd7; inner_control = 4'd0; src1 = '0; src2 = 64'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", result_out, 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        check("midreset_in_ready_after", 64'(in_ready), 64'd1);
        do_op("add_after_reset", 4'd0, 4'd0, 64'd40, 64'd2, 64'd42, 1);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
